mm_round_controller: RTL and testbench

- Sequences one Mastermind round between the debounced button edges and the game-state/renderer datapath.
- Latches a pseudo-random secret and lets the player edit a guess peg by peg.
- Scores each submitted guess sequentially (exact hits, then colour hits).
- Publishes tries, last score and win/lose for the VGA renderer and segment display; runs on CLK_PLL beside the existing game-state logic.

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_lfsr16.sv | 26 ++
 rtl/mm_round_controller.sv | 192 +++++++++++++++++++
 tb/tb_mm_round_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the Mastermind round controller.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        EDIT        = 3'd1,
        SCORE_EXACT = 3'd2,
        SCORE_COLOR = 3'd3,
        RESULT      = 3'd4,
        WON         = 3'd5,
        LOST        = 3'd6
    } state_t;

    // Widest peg the controller supports (8 colours).
    localparam int unsigned PEG_MAX_W = 3;
    typedef logic [PEG_MAX_W-1:0] peg_t;

    // Fibonacci LFSR: seed and feedback taps 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_CODE_LEN  = 4;
    localparam int DEF_COLORS    = 6;
    localparam int DEF_MAX_TRIES = 10;

endpackage

// File: rtl/mm_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; only RST reseeds it.
module mm_lfsr16
    import mm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic feedback;

    // Feedback is the parity of the tapped bits.
    always_comb begin
        feedback = ^(value & LFSR_TAPS);
    end

    // Shift every cycle regardless of controller state.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/mm_round_controller.sv
// Sequences one Mastermind round: secret latch, guess editing, scoring, result.
module mm_round_controller
    import mm_pkg::*;
#(
    parameter int CODE_LEN  = DEF_CODE_LEN,
    parameter int COLORS    = DEF_COLORS,
    parameter int MAX_TRIES = DEF_MAX_TRIES
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               start,
    input  logic                               btn_color,
    input  logic                               btn_move,
    input  logic                               btn_submit,
    input  logic                               dbg_secret_we,
    input  logic [CODE_LEN*$clog2(COLORS)-1:0] dbg_secret,
    output logic [2:0]                         state,
    output logic [CODE_LEN*$clog2(COLORS)-1:0] guess,
    output logic [2:0]                         cursor,
    output logic [3:0]                         tries,
    output logic [2:0]                         black,
    output logic [2:0]                         white,
    output logic                               result_valid,
    output logic                               won,
    output logic                               lost
);

    localparam int          CW = $clog2(COLORS);
    localparam int          GW = CODE_LEN * CW;
    localparam int unsigned HN = 1 << CW;

    state_t          cur, nxt;
    logic [15:0]     lfsr;
    logic [GW-1:0]   secret;
    logic [GW-1:0]   fresh;
    logic [2:0]      step;
    logic [2:0]      acc;
    logic [2:0]      total;
    logic [2:0]      hs [HN];
    logic [2:0]      hg [HN];
    logic [CW-1:0]   edit_peg;
    logic [CW-1:0]   sec_peg;
    logic [CW-1:0]   gue_peg;
    logic [2:0]      hs_c, hg_c;
    logic            unused_lfsr_bits;

    mm_lfsr16 u_lfsr (
        .clk   (CLK),
        .rst   (RST),
        .value (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr;

    function automatic logic [CW-1:0] peg_of(input logic [GW-1:0] code, input logic [2:0] idx);
        return code[idx*CW +: CW];
    endfunction

    assign state = cur;
    assign won   = (cur == WON);
    assign lost  = (cur == LOST);

    // Fold each LFSR field into the colour range to form a candidate secret.
    always_comb begin
        logic [CW-1:0] raw;
        raw   = '0;
        fresh = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            raw = lfsr[CW*i +: CW];
            if ({1'b0, raw} >= (CW+1)'(COLORS)) begin
                fresh[CW*i +: CW] = raw - CW'(COLORS);
            end else begin
                fresh[CW*i +: CW] = raw;
            end
        end
    end

    // Operand selection for editing and scoring.
    always_comb begin
        edit_peg = peg_of(guess, cursor);
        sec_peg  = peg_of(secret, step);
        gue_peg  = peg_of(guess, step);
        hs_c     = hs[step[CW-1:0]];
        hg_c     = hg[step[CW-1:0]];
    end

    // Next-state logic.
    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE, WON, LOST: if (start) nxt = EDIT;
            EDIT:            if (btn_submit) nxt = SCORE_EXACT;
            SCORE_EXACT:     if (step == 3'(CODE_LEN-1)) nxt = SCORE_COLOR;
            SCORE_COLOR:     if (step == 3'(COLORS-1)) nxt = RESULT;
            RESULT: begin
                if (acc == 3'(CODE_LEN)) begin
                    nxt = WON;
                end else if (tries + 4'd1 == 4'(MAX_TRIES)) begin
                    nxt = LOST;
                end else begin
                    nxt = EDIT;
                end
            end
            default:         nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Datapath: round setup, guess editing, scoring accumulators and results.
    always_ff @(posedge CLK) begin
        if (RST) begin
            secret       <= '0;
            guess        <= '0;
            cursor       <= '0;
            tries        <= '0;
            black        <= '0;
            white        <= '0;
            result_valid <= 1'b0;
            step         <= '0;
            acc          <= '0;
            total        <= '0;
            for (int unsigned c = 0; c < HN; c++) begin
                hs[c] <= '0;
                hg[c] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            case (cur)
                IDLE, WON, LOST: begin
                    if (start) begin
                        secret <= fresh;
                        guess  <= '0;
                        cursor <= '0;
                        tries  <= '0;
                        black  <= '0;
                        white  <= '0;
                    end
                end
                EDIT: begin
                    if (btn_submit) begin
                        step  <= '0;
                        acc   <= '0;
                        total <= '0;
                        for (int unsigned c = 0; c < HN; c++) begin
                            hs[c] <= '0;
                            hg[c] <= '0;
                        end
                    end else if (btn_move) begin
                        cursor <= (cursor == 3'(CODE_LEN-1)) ? '0 : cursor + 3'd1;
                    end else if (btn_color) begin
                        guess[cursor*CW +: CW] <= (edit_peg == CW'(COLORS-1)) ? '0 : edit_peg + 1'b1;
                    end
                end
                SCORE_EXACT: begin
                    if (sec_peg == gue_peg) begin
                        acc <= acc + 3'd1;
                    end
                    hs[sec_peg] <= hs[sec_peg] + 3'd1;
                    hg[gue_peg] <= hg[gue_peg] + 3'd1;
                    step <= (step == 3'(CODE_LEN-1)) ? '0 : step + 3'd1;
                end
                SCORE_COLOR: begin
                    total <= total + ((hs_c < hg_c) ? hs_c : hg_c);
                    step  <= (step == 3'(COLORS-1)) ? '0 : step + 3'd1;
                end
                RESULT: begin
                    black        <= acc;
                    white        <= total - acc;
                    result_valid <= 1'b1;
                    tries        <= tries + 4'd1;
                    if (nxt == EDIT) begin
                        cursor <= '0;
                    end
                end
                default: ;
            endcase
            // Test hook overrides the start latch but never disturbs an active score.
            if (dbg_secret_we && cur != SCORE_EXACT && cur != SCORE_COLOR) begin
                secret <= dbg_secret;
            end
        end
    end

endmodule

// File: tb/tb_mm_round_controller.sv
// Self-checking bench for mm_round_controller (default parameters).
module tb_mm_round_controller;

    localparam int S_IDLE = 0, S_EDIT = 1, S_SCORE_EXACT = 2, S_WON = 5, S_LOST = 6;
    localparam int LAT = 11;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, btn_color = 1'b0, btn_move = 1'b0, btn_submit = 1'b0;
    logic        dbg_secret_we = 1'b0;
    logic [11:0] dbg_secret = '0;
    logic [2:0]  state;
    logic [11:0] guess;
    logic [2:0]  cursor;
    logic [3:0]  tries;
    logic [2:0]  black, white;
    logic        result_valid, won, lost;

    int checks = 0;
    int errors = 0;
    logic [11:0] cur_guess = '0;

    mm_round_controller #(.CODE_LEN(4), .COLORS(6), .MAX_TRIES(10)) dut (
        .CLK(CLK), .RST(RST), .start(start), .btn_color(btn_color), .btn_move(btn_move),
        .btn_submit(btn_submit), .dbg_secret_we(dbg_secret_we), .dbg_secret(dbg_secret),
        .state(state), .guess(guess), .cursor(cursor), .tries(tries), .black(black),
        .white(white), .result_valid(result_valid), .won(won), .lost(lost)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] sec;
        logic [11:0] gs;
        int          eb;
        int          ew;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [11:0] pack(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    // Reference scoring: pair exact positions, then greedily pair leftover pegs by colour.
    function automatic void model_score(input logic [11:0] s, input logic [11:0] g,
                                        output int b, output int w);
        bit su [4];
        bit gu [4];
        logic [11:0] sv, gv;
        sv = s; gv = g; b = 0; w = 0;
        for (int i = 0; i < 4; i++) begin
            su[i] = (sv[i*3 +: 3] == gv[i*3 +: 3]);
            gu[i] = su[i];
            if (su[i]) b++;
        end
        for (int i = 0; i < 4; i++) begin
            if (!gu[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!su[j] && !gu[i] && sv[j*3 +: 3] == gv[i*3 +: 3]) begin
                        su[j] = 1'b1;
                        gu[i] = 1'b1;
                        w++;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic press_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic press_color();
        btn_color = 1'b1; tick(); btn_color = 1'b0;
    endtask

    task automatic press_move();
        btn_move = 1'b1; tick(); btn_move = 1'b0;
    endtask

    task automatic load_secret(input logic [11:0] s);
        dbg_secret_we = 1'b1; dbg_secret = s; tick(); dbg_secret_we = 1'b0;
    endtask

    // Edits every peg from the tracked current guess to the target, leaving cursor at 0.
    task automatic set_guess(input logic [11:0] target);
        logic [11:0] t, c;
        int n;
        t = target; c = cur_guess;
        for (int i = 0; i < 4; i++) begin
            n = (int'(t[i*3 +: 3]) - int'(c[i*3 +: 3]) + 6) % 6;
            for (int k = 0; k < n; k++) press_color();
            press_move();
        end
        cur_guess = target;
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (result_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic submit_and_wait(output int lat);
        btn_submit = 1'b1; tick(); btn_submit = 1'b0;
        wait_result(lat);
    endtask

    initial begin
        int lat, eb, ew, tries_m, exp_state, seen;
        logic [11:0] s, g;

        tbl[0] = '{pack(0,1,2,3), pack(3,2,1,0), 0, 4};
        tbl[1] = '{pack(1,1,2,2), pack(1,2,2,2), 3, 0};
        tbl[2] = '{pack(5,5,5,5), pack(0,0,0,5), 1, 0};
        tbl[3] = '{pack(0,1,2,3), pack(1,0,4,5), 0, 2};
        tbl[4] = '{pack(4,4,0,0), pack(0,0,4,4), 0, 4};

        // Reset state
        tick(); tick();
        RST = 1'b0;
        check("rst_state", int'(state), S_IDLE);
        check("rst_guess", int'(guess), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_tries", int'(tries), 0);
        check("rst_bw", int'({black, white}), 0);
        check("rst_flags", int'({result_valid, won, lost}), 0);

        // start with a button in IDLE: start wins, button dropped
        start = 1'b1; btn_color = 1'b1; tick(); start = 1'b0; btn_color = 1'b0;
        check("start_state", int'(state), S_EDIT);
        check("start_btn_dropped", int'(guess), 0);

        // Colour wrap and cursor wrap
        press_color();
        check("color_once", int'(guess), 1);
        for (int k = 0; k < 5; k++) press_color();
        check("color_wrap", int'(guess), 0);
        press_move();
        check("move_once", int'(cursor), 1);
        for (int k = 0; k < 3; k++) press_move();
        check("move_wrap", int'(cursor), 0);
        cur_guess = '0;

        // Exact win
        load_secret(pack(0,1,2,3));
        set_guess(pack(0,1,2,3));
        check("win_guess", int'(guess), int'(pack(0,1,2,3)));
        submit_and_wait(lat);
        check("win_latency", lat, LAT);
        check("win_black", int'(black), 4);
        check("win_white", int'(white), 0);
        check("win_tries", int'(tries), 1);
        check("win_won", int'(won), 1);
        check("win_state", int'(state), S_WON);
        tick();
        check("win_rv_pulse", int'(result_valid), 0);
        check("win_hold", int'(state), S_WON);

        press_start();
        cur_guess = '0;
        check("restart_state", int'(state), S_EDIT);
        check("restart_tries", int'(tries), 0);
        check("restart_won", int'(won), 0);
        check("restart_bw", int'({black, white}), 0);

        // Table-driven scoring
        for (int v = 0; v < 5; v++) begin
            load_secret(tbl[v].sec);
            set_guess(tbl[v].gs);
            submit_and_wait(lat);
            check("tbl_latency", lat, LAT);
            check("tbl_black", int'(black), tbl[v].eb);
            check("tbl_white", int'(white), tbl[v].ew);
            check("tbl_tries", int'(tries), v + 1);
            check("tbl_state", int'(state), S_EDIT);
            check("tbl_cursor", int'(cursor), 0);
        end

        // Loss after ten misses
        load_secret(pack(5,5,5,5));
        set_guess(pack(0,0,0,0));
        for (int t = 6; t <= 10; t++) begin
            submit_and_wait(lat);
            check("loss_latency", lat, LAT);
            check("loss_tries", int'(tries), t);
            check("loss_state", int'(state), (t == 10) ? S_LOST : S_EDIT);
            check("loss_flag", int'(lost), (t == 10) ? 1 : 0);
        end
        press_start();
        cur_guess = '0;
        check("loss_restart_state", int'(state), S_EDIT);
        check("loss_restart_tries", int'(tries), 0);
        check("loss_restart_lost", int'(lost), 0);

        // Simultaneous submit/move/colour; secret write ignored while scoring
        press_move();
        press_color();
        cur_guess = pack(0,1,0,0);
        load_secret(pack(1,0,0,0));
        btn_submit = 1'b1; btn_move = 1'b1; btn_color = 1'b1;
        tick();
        btn_submit = 1'b0; btn_move = 1'b0; btn_color = 1'b0;
        check("prio_state", int'(state), S_SCORE_EXACT);
        check("prio_guess", int'(guess), int'(pack(0,1,0,0)));
        check("prio_cursor", int'(cursor), 1);
        load_secret(pack(0,1,0,0));
        wait_result(lat);
        check("prio_latency", lat, LAT - 1);
        check("prio_black", int'(black), 2);
        check("prio_white", int'(white), 2);
        check("prio_cursor_after", int'(cursor), 0);
        tries_m = 1;

        // Randomized rounds against the reference scorer
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 4; i++) begin
                s[i*3 +: 3] = 3'($urandom_range(0, 5));
                g[i*3 +: 3] = 3'($urandom_range(0, 5));
            end
            if (r % 7 == 3) g = s;
            load_secret(s);
            set_guess(g);
            submit_and_wait(lat);
            model_score(s, g, eb, ew);
            tries_m++;
            exp_state = (eb == 4) ? S_WON : ((tries_m == 10) ? S_LOST : S_EDIT);
            check("rnd_latency", lat, LAT);
            check("rnd_black", int'(black), eb);
            check("rnd_white", int'(white), ew);
            check("rnd_tries", int'(tries), tries_m);
            check("rnd_state", int'(state), exp_state);
            if (exp_state != S_EDIT) begin
                press_start();
                tries_m = 0;
                cur_guess = '0;
            end
        end

        // Reset three cycles into scoring
        set_guess(pack(2,3,4,5));
        btn_submit = 1'b1; tick(); btn_submit = 1'b0;
        tick(); tick(); tick();
        RST = 1'b1; tick(); RST = 1'b0;
        check("midrst_state", int'(state), S_IDLE);
        check("midrst_guess", int'(guess), 0);
        check("midrst_cursor", int'(cursor), 0);
        check("midrst_tries", int'(tries), 0);
        check("midrst_bw", int'({black, white}), 0);
        check("midrst_flags", int'({result_valid, won, lost}), 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (result_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        check("midrst_idle_hold", int'(state), S_IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
